// File: rtl/status_scheduler_pkg.sv
// Shared board geometry, tile byte layout and update-entry format for the status scheduler.
package status_scheduler_pkg;
  localparam int NUM_TILES = 30;
  localparam int TILE_W    = 8;
  localparam int STATUS_W  = NUM_TILES * TILE_W;
  localparam int ENTRY_W   = 14;

  typedef enum logic [1:0] {
    COL_EMPTY   = 2'd0,
    COL_ABSENT  = 2'd1,
    COL_PRESENT = 2'd2,
    COL_CORRECT = 2'd3
  } colour_t;

  typedef struct packed {
    logic       cursor;
    colour_t    colour;
    logic [4:0] letter;
  } tile_t;

  typedef struct packed {
    logic       reveal;
    logic [4:0] tile;
    tile_t      data;
  } upd_t;

  typedef enum logic {ST_IDLE = 1'b0, ST_APPLY = 1'b1} state_t;
endpackage

// File: rtl/status_scheduler_upd_fifo.sv
// Synchronous update queue, registered pointers, data valid at the head with zero latency.
// A full queue refuses pushes even if a pop happens in the same cycle; clr flushes it.
module upd_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW + 1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      level <= level + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wptr] <= din;
  end
endmodule

// File: rtl/status_scheduler.sv
// Owns the 240-bit board status; queued tile updates land only after a frame tick, one pop per cycle.
// Apply starts two edges after vsync goes active; wr_ready drops when the queue is full or clr is high.
module status_scheduler
  import status_scheduler_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int MAX_PER_FRAME = 30,
  parameter int REVEAL_FRAMES = 12,
  parameter bit VSYNC_POL     = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   vsync,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [4:0]             wr_tile,
  input  logic [7:0]             wr_data,
  input  logic                   wr_reveal,
  input  logic                   clr,
  output logic [STATUS_W-1:0]    status,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int PW = $clog2(REVEAL_FRAMES + 1);
  localparam int BW = $clog2(MAX_PER_FRAME + 1);
  localparam int LW = $clog2(DEPTH) + 1;

  state_t        state;
  logic [PW-1:0] pace_cnt;
  logic [BW-1:0] budget;
  logic          vs_q;
  logic          tick;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          last;
  upd_t          wr_upd;
  upd_t          head;

  assign wr_ready = !fifo_full && !clr;
  assign push     = wr_valid && wr_ready;
  assign pop      = (state == ST_APPLY);
  assign wr_upd   = {wr_reveal, wr_tile, wr_data};
  assign busy     = !fifo_empty || (state == ST_APPLY) || (pace_cnt != '0);

  // A pop ends the frame's batch if it drains the queue, spends the budget, or starts an animation step.
  assign last = ((fifo_level == LW'(1)) && !push) || (budget == BW'(1)) || head.reveal;

  upd_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push),
    .din   (wr_upd),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= !VSYNC_POL;
      tick <= 1'b0;
    end else begin
      vs_q <= vsync;
      tick <= (vsync == VSYNC_POL) && (vs_q != VSYNC_POL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      budget   <= '0;
      pace_cnt <= '0;
    end else if (clr) begin
      state    <= ST_IDLE;
      budget   <= '0;
      pace_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick) begin
            if (pace_cnt > PW'(1)) begin
              pace_cnt <= pace_cnt - PW'(1);
            end else begin
              pace_cnt <= '0;
              if (!fifo_empty) begin
                state  <= ST_APPLY;
                budget <= BW'(MAX_PER_FRAME);
              end
            end
          end
        end
        ST_APPLY: begin
          budget <= budget - BW'(1);
          if (last) begin
            state <= ST_IDLE;
            if (head.reveal) pace_cnt <= PW'(REVEAL_FRAMES);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Out-of-range tile indices match no decoder slot and are silently dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status <= '0;
    end else if (clr) begin
      status <= '0;
    end else if (state == ST_APPLY) begin
      for (int t = 0; t < NUM_TILES; t++) begin
        if (head.tile == 5'(t)) status[t*TILE_W +: TILE_W] <= head.data;
      end
    end
  end
endmodule

// File: tb/tb_status_scheduler.sv
// Directed bench for status_scheduler with a queue-level board model checked every cycle.
module tb_status_scheduler;
  localparam int DEPTH = 8;
  localparam int MAXPF = 3;
  localparam int REV   = 12;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         vsync;
  logic         wr_valid;
  logic         wr_ready;
  logic [4:0]   wr_tile;
  logic [7:0]   wr_data;
  logic         wr_reveal;
  logic         clr;
  logic [239:0] status;
  logic         busy;
  logic [3:0]   fifo_level;

  int n_tests = 0;
  int n_fail  = 0;

  status_scheduler #(
    .DEPTH(DEPTH), .MAX_PER_FRAME(MAXPF), .REVEAL_FRAMES(REV), .VSYNC_POL(1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync      (vsync),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_tile    (wr_tile),
    .wr_data    (wr_data),
    .wr_reveal  (wr_reveal),
    .clr        (clr),
    .status     (status),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [239:0] act, input logic [239:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] tile_of(input int t);
    return status[t*8 +: 8];
  endfunction

  // ---------------- model: queue of entries, board array, frame pacing in whole frames
  logic [13:0] mq[$];
  logic [7:0]  mboard [30];
  int          m_left;      // pops still allowed in the current batch, 0 when not applying
  int          m_pace;      // pacing count loaded by a reveal
  bit          m_tick_due;
  logic        m_vs_prev;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        foreach (mboard[i]) mboard[i] = 8'h00;
        m_left = 0; m_pace = 0; m_tick_due = 0; m_vs_prev = 1'b1;
      end else begin
        bit          tick_now;
        bit          push_ok;
        int          n_before;
        logic [13:0] e;
        tick_now   = m_tick_due;
        m_tick_due = (vsync == 1'b0) && (m_vs_prev == 1'b1);
        m_vs_prev  = vsync;
        if (clr) begin
          mq.delete();
          foreach (mboard[i]) mboard[i] = 8'h00;
          m_left = 0; m_pace = 0;
        end else begin
          n_before = mq.size();
          push_ok  = wr_valid && (n_before < DEPTH);
          if (m_left > 0) begin
            e = mq.pop_front();
            if (e[12:8] < 30) mboard[e[12:8]] = e[7:0];
            m_left--;
            if (e[13]) begin
              m_left = 0;
              m_pace = REV;
            end else if (mq.size() == 0 && !push_ok) begin
              m_left = 0;
            end
          end else if (tick_now) begin
            if (m_pace > 1) m_pace--;
            else begin
              m_pace = 0;
              if (n_before > 0) m_left = MAXPF;
            end
          end
          if (push_ok) mq.push_back({wr_reveal, wr_tile, wr_data});
        end
      end
    end
  end

  initial begin
    logic [239:0] exp_status;
    forever begin
      @(negedge clk);
      for (int t = 0; t < 30; t++) exp_status[t*8 +: 8] = mboard[t];
      chk("model_status", status, exp_status);
      chk("model_level", 240'(fifo_level), 240'(mq.size()));
      chk("model_busy", 240'(busy), 240'((mq.size() > 0) || (m_left > 0) || (m_pace > 0)));
      chk("model_wr_ready", 240'(wr_ready), 240'((mq.size() < DEPTH) && !clr));
    end
  end

  // ---------------- stimulus
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic frame(input int n);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b0;
      cyc(2);
      vsync = 1'b1;
      cyc(14);
    end
  endtask

  task automatic push(input logic [4:0] t, input logic [7:0] d, input logic r);
    int n;
    n = 0;
    wr_valid = 1'b1; wr_tile = t; wr_data = d; wr_reveal = r;
    while (!wr_ready && n < 50) begin
      cyc(1);
      n++;
    end
    chk("push_accept", 240'(wr_ready), 240'(1));
    cyc(1);
    wr_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [239:0] snap;
    rst_n = 1'b0; vsync = 1'b1; wr_valid = 1'b0; wr_tile = '0;
    wr_data = '0; wr_reveal = 1'b0; clr = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // 1: reset mid-frame with a queued update and pushes during reset
    push(5'd5, 8'h55, 1'b0);
    vsync = 1'b0;
    cyc(1);
    rst_n = 1'b0;
    #1;
    chk("rst_status", status, '0);
    chk("rst_level", 240'(fifo_level), 240'(0));
    chk("rst_busy", 240'(busy), 240'(0));
    vsync = 1'b1; wr_valid = 1'b1; wr_tile = 5'd6; wr_data = 8'h66;
    cyc(3);
    wr_valid = 1'b0;
    rst_n = 1'b1;
    frame(2);
    chk("idle_status", status, '0);
    chk("idle_busy", 240'(busy), 240'(0));
    chk("idle_wr_ready", 240'(wr_ready), 240'(1));
    chk("idle_level", 240'(fifo_level), 240'(0));

    // 2: single update waits for the tick, lands two edges after it is raised
    push(5'd7, 8'h43, 1'b0);
    cyc(20);
    chk("no_tick_hold", status, '0);
    chk("no_tick_level", 240'(fifo_level), 240'(1));
    vsync = 1'b0;
    cyc(2);
    chk("tick_not_yet", 240'(tile_of(7)), 240'(0));
    cyc(1);
    chk("tile7_applied", status, 240'(8'h43) << 56);
    chk("tile7_busy_drop", 240'(busy), 240'(0));
    vsync = 1'b1;
    cyc(13);

    // 3: five reveals, one per 12 frames
    for (int i = 0; i < 5; i++) push(5'(i), {3'b011, 5'(i + 1)}, 1'b1);
    frame(1);
    chk("rev_tile0", 240'(tile_of(0)), 240'(8'h61));
    chk("rev_tile1_wait", 240'(tile_of(1)), 240'(0));
    for (int k = 1; k < 5; k++) begin
      frame(11);
      chk("rev_pace_hold", 240'(tile_of(k)), 240'(0));
      frame(1);
      chk("rev_step", 240'(tile_of(k)), 240'(8'h61 + k));
      if (k < 4) chk("rev_next_wait", 240'(tile_of(k + 1)), 240'(0));
    end
    chk("rev_busy_pacing", 240'(busy), 240'(1));
    frame(12);
    chk("rev_busy_done", 240'(busy), 240'(0));

    // 4: fill the queue, stall, then budget-limited drain
    for (int i = 0; i < DEPTH; i++) push(5'(10 + i), 8'h80 | 8'(i + 1), 1'b0);
    chk("full_level", 240'(fifo_level), 240'(8));
    chk("full_ready", 240'(wr_ready), 240'(0));
    wr_valid = 1'b1; wr_tile = 5'd18; wr_data = 8'h99; wr_reveal = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("full_stall", 240'(wr_ready), 240'(0));
      cyc(1);
    end
    wr_valid = 1'b0;
    chk("full_level_hold", 240'(fifo_level), 240'(8));
    frame(1);
    chk("budget_level", 240'(fifo_level), 240'(5));
    chk("budget_ready", 240'(wr_ready), 240'(1));
    chk("budget_tile12", 240'(tile_of(12)), 240'(8'h83));
    chk("budget_tile13", 240'(tile_of(13)), 240'(0));
    frame(2);
    chk("drain_level", 240'(fifo_level), 240'(0));
    chk("drain_tile17", 240'(tile_of(17)), 240'(8'h88));
    chk("stall_dropped", 240'(tile_of(18)), 240'(0));

    // 5: out-of-range tile discarded, following entry applied
    snap = status;
    push(5'd31, 8'hFF, 1'b0);
    push(5'd2, 8'h01, 1'b0);
    frame(1);
    snap[23:16] = 8'h01;
    chk("discard_31", status, snap);

    // 6: clr during APPLY drops the same-cycle write
    push(5'd20, 8'h21, 1'b0);
    push(5'd21, 8'h22, 1'b0);
    push(5'd22, 8'h23, 1'b0);
    vsync = 1'b0;
    cyc(3);
    chk("clr_pre_tile20", 240'(tile_of(20)), 240'(8'h21));
    clr = 1'b1; wr_valid = 1'b1; wr_tile = 5'd23; wr_data = 8'h7F;
    #1;
    chk("clr_ready", 240'(wr_ready), 240'(0));
    cyc(1);
    clr = 1'b0; wr_valid = 1'b0;
    chk("clr_status", status, '0);
    chk("clr_level", 240'(fifo_level), 240'(0));
    chk("clr_busy", 240'(busy), 240'(0));
    vsync = 1'b1;
    cyc(14);
    frame(1);
    chk("clr_write_dropped", status, '0);

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
